// File: rtl/state_sequencer.sv
// Next-state generator for the external 4-bit state register, with
// dwell counters, load-back check and illegal-code detection.
module state_sequencer #(
    parameter int ARM_CYCLES = 4,
    parameter int RUN_CYCLES = 8,
    parameter int HOLD_MAX   = 16,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] current_state,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       resume,
    input  logic       fault,
    input  logic       ack,
    output logic [3:0] next_state,
    output logic       busy,
    output logic       done,
    output logic       fault_active,
    output logic       illegal_seen,
    output logic       mismatch
);

    localparam logic [3:0] S_IDLE  = 4'h0;
    localparam logic [3:0] S_ARM   = 4'h1;
    localparam logic [3:0] S_RUN   = 4'h2;
    localparam logic [3:0] S_HOLD  = 4'h3;
    localparam logic [3:0] S_DONE  = 4'h4;
    localparam logic [3:0] S_FAULT = 4'hF;

    localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] state_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic [3:0]       exp_q;
    logic             valid_q;
    logic [3:0]       rule_next;

    logic is_idle, is_arm, is_run, is_hold, is_done, is_fault;
    logic illegal, load_err;

    assign is_idle  = (current_state == S_IDLE);
    assign is_arm   = (current_state == S_ARM);
    assign is_run   = (current_state == S_RUN);
    assign is_hold  = (current_state == S_HOLD);
    assign is_done  = (current_state == S_DONE);
    assign is_fault = (current_state == S_FAULT);

    assign illegal  = ~(is_idle | is_arm | is_run |
                        is_hold | is_done | is_fault);
    assign load_err = valid_q && (current_state != exp_q);

    // State register side: counters, issued-code shadow, sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_cnt    <= '0;
            run_cnt      <= '0;
            exp_q        <= S_IDLE;
            valid_q      <= 1'b0;
            illegal_seen <= 1'b0;
            mismatch     <= 1'b0;
        end else begin
            exp_q   <= next_state;
            valid_q <= 1'b1;
            if (illegal)
                illegal_seen <= 1'b1;
            if (load_err)
                mismatch <= 1'b1;
            if (next_state != current_state)
                state_cnt <= '0;
            else if (~&state_cnt)
                state_cnt <= state_cnt + 1'b1;
            if (next_state == S_ARM)
                run_cnt <= '0;
            else if (is_run && next_state == S_RUN && ~&run_cnt)
                run_cnt <= run_cnt + 1'b1;
        end
    end

    always_comb begin
        rule_next = current_state;
        unique case (1'b1)
            is_idle: begin
                if (start)
                    rule_next = S_ARM;
            end
            is_arm: begin
                if (state_cnt == ARM_LAST)
                    rule_next = S_RUN;
            end
            is_run: begin
                if (pause)
                    rule_next = S_HOLD;
                else if (run_cnt == RUN_LAST)
                    rule_next = S_DONE;
            end
            is_hold: begin
                if (resume)
                    rule_next = S_RUN;
                else if (state_cnt == HOLD_LAST)
                    rule_next = S_FAULT;
            end
            is_done: begin
                if (ack)
                    rule_next = S_IDLE;
            end
            is_fault: begin
                if (ack && !fault)
                    rule_next = S_IDLE;
            end
            default: rule_next = S_FAULT;
        endcase
    end

    // Global overrides ahead of the per-state rule
    always_comb begin
        next_state = rule_next;
        if (reset)
            next_state = S_IDLE;
        else if (fault)
            next_state = S_FAULT;
        else if (illegal || load_err)
            next_state = S_FAULT;
        else if (stop && !is_fault)
            next_state = S_IDLE;
    end

    always_comb begin
        busy         = is_arm | is_run | is_hold;
        done         = is_done;
        fault_active = is_fault;
    end

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer: models the state register and checks
// against a rule-level reference model plus directed scenarios.
module tb_state_sequencer;

    localparam int ARM_C  = 4;
    localparam int RUN_C  = 8;
    localparam int HOLD_C = 16;
    localparam int SAT    = 65535;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cs;
    logic       start, stop, pause, resume, fault, ack;
    logic [3:0] next_state;
    logic       busy, done, fault_active, illegal_seen, mismatch;
    logic       ovr_en;
    logic [3:0] ovr_val;

    int n_checks = 0;
    int n_errors = 0;

    int         m_dwell, m_run;
    logic [3:0] m_exp;
    bit         m_valid, m_ill, m_mm;

    state_sequencer #(
        .ARM_CYCLES(ARM_C),
        .RUN_CYCLES(RUN_C),
        .HOLD_MAX  (HOLD_C),
        .CNT_W     (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .current_state(cs),
        .start        (start),
        .stop         (stop),
        .pause        (pause),
        .resume       (resume),
        .fault        (fault),
        .ack          (ack),
        .next_state   (next_state),
        .busy         (busy),
        .done         (done),
        .fault_active (fault_active),
        .illegal_seen (illegal_seen),
        .mismatch     (mismatch)
    );

    always #5 clk = ~clk;

    // The external state register, with an override for fault injection
    always @(posedge clk or posedge reset) begin
        if (reset)
            cs <= 4'h0;
        else if (ovr_en)
            cs <= ovr_val;
        else
            cs <= next_state;
    end

    function automatic bit legal(input logic [3:0] s);
        return (s <= 4'h4) || (s == 4'hF);
    endfunction

    function automatic logic [3:0] model_next();
        if (reset) return 4'h0;
        if (fault) return 4'hF;
        if (!legal(cs)) return 4'hF;
        if (m_valid && cs != m_exp) return 4'hF;
        if (stop && cs != 4'hF) return 4'h0;
        case (cs)
            4'h0: return start ? 4'h1 : 4'h0;
            4'h1: return (m_dwell == ARM_C - 1) ? 4'h2 : 4'h1;
            4'h2: begin
                if (pause) return 4'h3;
                return (m_run == RUN_C - 1) ? 4'h4 : 4'h2;
            end
            4'h3: begin
                if (resume) return 4'h2;
                return (m_dwell == HOLD_C - 1) ? 4'hF : 4'h3;
            end
            4'h4: return ack ? 4'h0 : 4'h4;
            default: return ack ? 4'h0 : 4'hF;
        endcase
    endfunction

    function automatic logic [4:0] model_flags();
        logic b;
        b = (cs == 4'h1) || (cs == 4'h2) || (cs == 4'h3);
        return {b, cs == 4'h4, cs == 4'hF, m_ill, m_mm};
    endfunction

    task automatic model_reset();
        m_dwell = 0;
        m_run   = 0;
        m_exp   = 4'h0;
        m_valid = 0;
        m_ill   = 0;
        m_mm    = 0;
    endtask

    task automatic set_in(input bit s, input bit sp, input bit p,
                          input bit r, input bit f, input bit a);
        start  = s;
        stop   = sp;
        pause  = p;
        resume = r;
        fault  = f;
        ack    = a;
    endtask

    // One clock edge; the model advances on what the register sees
    task automatic tick();
        logic [3:0] cs_b, en_b;
        cs_b = cs;
        en_b = model_next();
        @(posedge clk);
        if (!legal(cs_b)) m_ill = 1;
        if (m_valid && cs_b != m_exp) m_mm = 1;
        if (en_b != cs_b) m_dwell = 0;
        else if (m_dwell < SAT) m_dwell++;
        if (en_b == 4'h1) m_run = 0;
        else if (cs_b == 4'h2 && en_b == 4'h2) m_run++;
        m_exp   = en_b;
        m_valid = 1;
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0);
        ovr_en = 0;
        reset  = 1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic go_run();
        int n;
        set_in(1, 0, 0, 0, 0, 0);
        #2;
        tick();
        start = 0;
        n = 0;
        while (cs != 4'h2 && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (cs !== 4'h2) begin
            n_errors++;
            $display("FAIL go_run: state %h, wanted 2", cs);
        end
    endtask

    task automatic test_reset();
        reset  = 1;
        ovr_en = 0;
        ovr_val = 0;
        set_in(1, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        n_checks++;
        if (next_state !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_next: got %h want 0", next_state);
        end
        n_checks++;
        if ({busy, done, fault_active, illegal_seen, mismatch} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, done, fault_active, illegal_seen, mismatch});
        end
        do_reset();
    endtask

    task automatic test_nominal();
        do_reset();
        set_in(1, 0, 0, 0, 0, 0);
        #2;
        n_checks++;
        if (next_state !== 4'h1) begin
            n_errors++;
            $display("FAIL nom_start: got %h want 1", next_state);
        end
        for (int e = 1; e <= 13; e++) begin
            tick();
            start = 0;
            #2;
            if (e == 1 || e == 5 || e == 13) begin
                n_checks++;
                if (cs !== (e == 1 ? 4'h1 : e == 5 ? 4'h2 : 4'h4)) begin
                    n_errors++;
                    $display("FAIL nom_edge%0d: state %h", e, cs);
                end
            end
            n_checks++;
            if (next_state !== model_next()) begin
                n_errors++;
                $display("FAIL nom_next e%0d: got %h want %h",
                         e, next_state, model_next());
            end
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL nom_done: got %b want 1", done);
        end
        ack = 1;
        #2;
        tick();
        ack = 0;
        n_checks++;
        if (cs !== 4'h0) begin
            n_errors++;
            $display("FAIL nom_ack: state %h want 0", cs);
        end
    endtask

    task automatic test_pause();
        int n;
        do_reset();
        go_run();
        for (int i = 0; i < 3; i++) tick();
        pause = 1;
        #2;
        n_checks++;
        if (next_state !== 4'h3) begin
            n_errors++;
            $display("FAIL pause_next: got %h want 3", next_state);
        end
        tick();
        pause = 0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (cs !== 4'h3) begin
            n_errors++;
            $display("FAIL pause_hold: state %h want 3", cs);
        end
        resume = 1;
        #2;
        tick();
        resume = 0;
        n = 0;
        while (cs != 4'h4 && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 5) begin
            n_errors++;
            $display("FAIL pause_runs: got %0d run cycles want 5", n);
        end
    endtask

    task automatic test_hold_timeout();
        int n;
        do_reset();
        go_run();
        pause = 1;
        #2;
        tick();
        n = 0;
        while (cs != 4'hF && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 16 || fault_active !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_tmo: edges %0d fa %b want 16/1",
                     n, fault_active);
        end
        set_in(0, 0, 0, 0, 1, 1);
        #2;
        tick();
        n_checks++;
        if (cs !== 4'hF) begin
            n_errors++;
            $display("FAIL hold_ackf: state %h want F", cs);
        end
        fault = 0;
        #2;
        tick();
        ack = 0;
        n_checks++;
        if (cs !== 4'h0) begin
            n_errors++;
            $display("FAIL hold_ack: state %h want 0", cs);
        end
    endtask

    task automatic test_priority();
        int n;
        do_reset();
        go_run();
        set_in(0, 1, 0, 0, 1, 0);
        #2;
        n_checks++;
        if (next_state !== 4'hF) begin
            n_errors++;
            $display("FAIL prio_fs: got %h want F", next_state);
        end
        do_reset();
        go_run();
        tick();
        tick();
        stop = 1;
        #2;
        tick();
        stop = 0;
        n_checks++;
        if (cs !== 4'h0) begin
            n_errors++;
            $display("FAIL prio_stop: state %h want 0", cs);
        end
        start = 1;
        #2;
        tick();
        start = 0;
        n = 1;
        while (cs != 4'h4 && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 13) begin
            n_errors++;
            $display("FAIL prio_rearm: done at edge %0d want 13", n);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        tick();
        ovr_en  = 1;
        ovr_val = 4'h9;
        tick();
        ovr_en = 0;
        #2;
        n_checks++;
        if (next_state !== 4'hF || illegal_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL ill_detect: ns %h ill %b want F/0",
                     next_state, illegal_seen);
        end
        tick();
        ack = 1;
        for (int i = 0; i < 4; i++) tick();
        ack = 0;
        n_checks++;
        if (illegal_seen !== 1'b1 || cs !== 4'h0) begin
            n_errors++;
            $display("FAIL ill_sticky: ill %b state %h want 1/0",
                     illegal_seen, cs);
        end
        do_reset();
        n_checks++;
        if (illegal_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL ill_clear: got %b want 0", illegal_seen);
        end
    endtask

    task automatic test_mismatch_reset();
        int n;
        do_reset();
        go_run();
        ovr_en  = 1;
        ovr_val = 4'h3;
        tick();
        ovr_en = 0;
        #2;
        n_checks++;
        if (next_state !== 4'hF || mismatch !== 1'b0) begin
            n_errors++;
            $display("FAIL mm_detect: ns %h mm %b want F/0",
                     next_state, mismatch);
        end
        tick();
        n_checks++;
        if (mismatch !== 1'b1 || cs !== 4'hF) begin
            n_errors++;
            $display("FAIL mm_flag: mm %b state %h want 1/F", mismatch, cs);
        end
        ack = 1;
        #2;
        tick();
        ack = 0;
        go_run();
        tick();
        tick();
        reset = 1;
        #1;
        n_checks++;
        if (next_state !== 4'h0 || cs !== 4'h0 ||
            {busy, done, fault_active, illegal_seen, mismatch} !== 5'b0) begin
            n_errors++;
            $display("FAIL mid_reset: ns %h st %h flags %b want 0",
                     next_state, cs,
                     {busy, done, fault_active, illegal_seen, mismatch});
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
        start = 1;
        #2;
        tick();
        start = 0;
        n = 1;
        while (cs != 4'h4 && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 13) begin
            n_errors++;
            $display("FAIL reset_rerun: done at edge %0d want 13", n);
        end
    endtask

    task automatic test_random();
        logic [3:0] en;
        logic [4:0] ef;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(199) == 0) do_reset();
            set_in($urandom_range(1) == 0,
                   $urandom_range(24) == 0,
                   $urandom_range(7) == 0,
                   $urandom_range(3) == 0,
                   $urandom_range(39) == 0,
                   $urandom_range(3) == 0);
            ovr_en  = ($urandom_range(79) == 0);
            ovr_val = 4'($urandom_range(15));
            #2;
            en = model_next();
            ef = model_flags();
            n_checks++;
            if (next_state !== en) begin
                n_errors++;
                $display("FAIL rand_next c%0d: got %h want %h st %h",
                         c, next_state, en, cs);
            end
            n_checks++;
            if ({busy, done, fault_active, illegal_seen, mismatch} !== ef) begin
                n_errors++;
                $display("FAIL rand_flags c%0d: got %b want %b", c,
                         {busy, done, fault_active, illegal_seen, mismatch},
                         ef);
            end
            tick();
            ovr_en = 0;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_pause();
        test_hold_timeout();
        test_priority();
        test_illegal();
        test_mismatch_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/state_sequencer.md
Name: state_sequencer

Overview:
- Next-state generator paired with the 4-bit `current_state` register bank; this block is the driving side of that interface.
- Reads `current_state`, inputs, and internal dwell counters, and drives `next_state`; the register loads `next_state` on each clock edge.
- Also checks that the register actually loaded what was issued, and flags illegal state codes.

Parameters:
ARM_CYCLES, 4, cycles spent in ARM before entering RUN (>=1)
RUN_CYCLES, 8, cumulative RUN cycles before DONE, HOLD time excluded (>=1)
HOLD_MAX, 16, max consecutive cycles in HOLD before FAULT (>=1)
CNT_W, 16, width of internal dwell counters; every cycle parameter must be < 2^CNT_W

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
current_state  input  4  output of the state register
start  input  1  request to begin a sequence
stop  input  1  abort to IDLE
pause  input  1  RUN -> HOLD request
resume  input  1  HOLD -> RUN request
fault  input  1  external fault
ack  input  1  acknowledge DONE/FAULT
next_state  output  4  state code to load on next edge
busy  output  1  current_state is ARM, RUN or HOLD
done  output  1  current_state == DONE
fault_active  output  1  current_state == FAULT
illegal_seen  output  1  sticky: illegal code observed
mismatch  output  1  sticky: register did not load issued code

Behaviour:
- Encoding: IDLE=4'h0, ARM=4'h1, RUN=4'h2, HOLD=4'h3, DONE=4'h4, FAULT=4'hF. Codes 5..E are illegal.
- The state register is reset in the same reset domain to IDLE.
- While reset is high:
  - next_state=0, illegal_seen=0, mismatch=0.
  - All counters and the expected-state register clear to 0.
  - busy, done and fault_active follow current_state.
- next_state is combinational: zero latency from inputs to next_state, one edge to current_state.
- Priority in every state: fault > illegal/mismatch detect > stop > state-specific rule.
  - fault=1 -> FAULT.
  - stop=1 -> IDLE, from any state except FAULT.
- Transitions:
  - IDLE: start -> ARM; else hold.
  - ARM: state_cnt == ARM_CYCLES-1 -> RUN; else hold.
  - RUN: pause -> HOLD (wins over completion); else run_cnt == RUN_CYCLES-1 -> DONE; else hold.
  - HOLD: resume -> RUN; else state_cnt == HOLD_MAX-1 -> FAULT; else hold.
  - DONE: ack -> IDLE; start ignored.
  - FAULT: ack & ~fault -> IDLE; stop ignored.
  - Illegal current_state -> FAULT; illegal_seen sets on the next edge.
- state_cnt:
  - Clears to 0 on any edge where next_state != current_state.
  - Otherwise increments, saturating at all-ones.
- run_cnt:
  - Clears when next_state==ARM.
  - Increments on edges where current_state==RUN and next_state==RUN.
  - Holds in HOLD; the RUN total is cumulative across pauses.
- Load check:
  - exp_q <= next_state every edge; valid_q is set one edge after reset release.
  - If valid_q and current_state != exp_q: next_state forced to FAULT that cycle, and mismatch sets on the next edge.
- illegal_seen and mismatch clear only on reset.
- Reset mid-sequence: everything returns to IDLE / zeros asynchronously; no partial counts survive.

Test Plan:
- Nominal run (ARM_CYCLES=4, RUN_CYCLES=8):
  - Stimulus: reset release, start pulse at cycle 0.
  - Required: current_state goes 1 at edge 1, 2 at edge 5, 4 at edge 13; done=1 from edge 13.
  - Then ack -> IDLE next edge.
- Pause and resume:
  - Stimulus: pause after 3 RUN cycles, hold 5 cycles, resume.
  - Required: DONE reached after exactly 5 further RUN cycles; HOLD time not counted.
- HOLD timeout (HOLD_MAX=16):
  - Stimulus: pause held with no resume.
  - Required: FAULT on the 16th edge in HOLD; fault_active=1.
  - ack with fault=0 -> IDLE; ack with fault=1 -> stays FAULT.
- Priority:
  - Stimulus: fault and stop together in RUN.
  - Required: FAULT.
  - Stimulus: stop in RUN.
  - Required: IDLE; a subsequent start re-arms with run_cnt=0.
- Illegal code:
  - Stimulus: force current_state=4'h9.
  - Required: next_state=4'hF the same cycle; illegal_seen=1 after the edge and sticky until reset.
- Mismatch and reset:
  - Stimulus: override the register to load 4'h3 while 4'h2 was issued.
  - Required: mismatch=1 after the following edge; next_state=F in the detection cycle.
  - Stimulus: assert reset mid-RUN.
  - Required: all outputs and counters 0 immediately; next_state=0.
